// File: rtl/jstk_spi_responder.sv
// SPI mode-0 responder for a joystick: returns a 40-bit snapshot of the stick
// position and buttons, and takes an LED command from the first byte the master
// sends. SCLK, SS and MOSI are oversampled through synchronizers on clk.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no frame in progress, MISO held low, SCLK ignored
// ACTIVE | frame in progress, shifting MOSI in and tx_sh out
// HOLD   | all 40 bits exchanged, waiting for SS to rise, MISO low
module jstk_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCLK,
    input  logic       SS,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] buttons,
    output logic [1:0] led,
    output logic       frame_done,
    output logic       frame_err
);

    localparam logic [2:0] FLUSH_N = 3'(SYNC_STAGES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   ss_d;
    logic [2:0]             flush_cnt;
    logic                   armed;
    logic [39:0]            tx_sh;
    logic [7:0]             rx_sh;
    logic [7:0]             cmd_byte;
    logic [5:0]             bit_cnt;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;
    assign ss_rise   = ~ss_d & ss_s;
    // A falling SS only starts a frame once SS has been seen high after reset,
    // so a frame interrupted by reset is never picked up halfway through.
    assign ss_fall   = ss_d & ~ss_s & armed;

    // Input synchronizers and previous-value registers for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    // Arm frame start once the synchronizer holds real data and SS reads high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flush_cnt <= 3'd0;
            armed     <= 1'b0;
        end else begin
            if (flush_cnt != FLUSH_N)
                flush_cnt <= flush_cnt + 3'd1;
            else if (ss_s)
                armed <= 1'b1;
        end
    end

    // Frame FSM: snapshot, shift in/out, and end-of-frame reporting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            MISO       <= 1'b0;
            led        <= 2'b00;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            bit_cnt    <= 6'd0;
            tx_sh      <= 40'd0;
            rx_sh      <= 8'd0;
            cmd_byte   <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    if (ss_fall) begin
                        tx_sh   <= {x_pos[7:0], 6'b0, x_pos[9:8],
                                    y_pos[7:0], 6'b0, y_pos[9:8],
                                    5'b0, buttons};
                        MISO    <= x_pos[7];
                        bit_cnt <= 6'd0;
                        rx_sh   <= 8'd0;
                        state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // SS rising wins over any SCLK edge seen in the same cycle.
                    if (ss_rise) begin
                        state     <= IDLE;
                        MISO      <= 1'b0;
                        frame_err <= 1'b1;
                    end else if (sclk_rise) begin
                        rx_sh   <= {rx_sh[6:0], mosi_s};
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd7)
                            cmd_byte <= {rx_sh[6:0], mosi_s};
                        if (bit_cnt == 6'd39) begin
                            state <= HOLD;
                            MISO  <= 1'b0;
                        end
                    end else if (sclk_fall) begin
                        tx_sh <= {tx_sh[38:0], 1'b0};
                        MISO  <= tx_sh[38];
                    end
                end
                HOLD: begin
                    MISO <= 1'b0;
                    if (ss_rise) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                        if (cmd_byte[7:2] == 6'b100000)
                            led <= cmd_byte[1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    MISO  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: a mode-0 SPI master with SCLK at clk/16.
module tb_jstk_spi_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       SCLK = 1'b0;
    logic       SS = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] x_pos = 10'h2A5;
    logic [9:0] y_pos = 10'h13C;
    logic [2:0] buttons = 3'b101;
    logic [1:0] led;
    logic       frame_done;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    localparam logic [47:0] GOOD = {40'hA5_02_3C_01_05, 8'h00};

    jstk_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .SCLK       (SCLK),
        .SS         (SS),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .buttons    (buttons),
        .led        (led),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI frame of nbits; optional x_pos change and reset at given bit indices.
    task automatic frame(input int nbits, input logic [47:0] mosi_v,
                         input int chg_bit, input int rst_bit,
                         output logic [47:0] miso_v, output int n_done,
                         output int n_err, output int n_both);
        miso_v = '0;
        n_done = 0;
        n_err  = 0;
        n_both = 0;
        wait_clk(8);
        SS = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) x_pos = 10'h3FF;
            if (i == rst_bit) begin
                rst = 1'b0;
                wait_clk(1);
                rst = 1'b1;
            end
            MOSI = mosi_v[47-i];
            wait_clk(8);
            SCLK = 1'b1;
            miso_v[47-i] = MISO;
            wait_clk(8);
            SCLK = 1'b0;
        end
        wait_clk(8);
        SS = 1'b1;
        for (int c = 0; c < 12; c++) begin
            wait_clk(1);
            if (frame_done) n_done++;
            if (frame_err) n_err++;
            if (frame_done && frame_err) n_both++;
        end
    endtask

    logic [47:0] miso_v;
    int n_done, n_err, n_both;

    initial begin
        wait_clk(3);
        chk("reset_miso", 48'(MISO), 48'h0);
        chk("reset_led", 48'(led), 48'h0);
        chk("reset_done", 48'(frame_done), 48'h0);
        chk("reset_err", 48'(frame_err), 48'h0);
        rst = 1'b1;
        wait_clk(10);

        // good frame, command 0x83
        frame(40, {8'h83, 40'h0}, -1, -1, miso_v, n_done, n_err, n_both);
        chk("good_miso", miso_v, GOOD);
        chk("good_done", 48'(n_done), 48'd1);
        chk("good_err", 48'(n_err), 48'd0);
        chk("good_led", 48'(led), 48'h3);

        // bad command 0x42
        frame(40, {8'h42, 40'h0}, -1, -1, miso_v, n_done, n_err, n_both);
        chk("badcmd_miso", miso_v, GOOD);
        chk("badcmd_done", 48'(n_done), 48'd1);
        chk("badcmd_led", 48'(led), 48'h3);

        // abort after 17 bits
        frame(17, {8'h81, 40'h0}, -1, -1, miso_v, n_done, n_err, n_both);
        chk("abort_miso", miso_v, GOOD & 48'hFFFF_8000_0000);
        chk("abort_err", 48'(n_err), 48'd1);
        chk("abort_done", 48'(n_done), 48'd0);
        chk("abort_led", 48'(led), 48'h3);

        // recovery frame 0x81
        frame(40, {8'h81, 40'h0}, -1, -1, miso_v, n_done, n_err, n_both);
        chk("recover_miso", miso_v, GOOD);
        chk("recover_done", 48'(n_done), 48'd1);
        chk("recover_led", 48'(led), 48'h1);

        // overrun: 48 bits, bits 41-48 must read 0
        frame(48, {8'h82, 40'h0}, -1, -1, miso_v, n_done, n_err, n_both);
        chk("overrun_miso", miso_v, GOOD);
        chk("overrun_done", 48'(n_done), 48'd1);
        chk("overrun_err", 48'(n_err), 48'd0);
        chk("overrun_led", 48'(led), 48'h2);

        // snapshot: x_pos changes mid-frame
        frame(40, {8'h83, 40'h0}, 3, -1, miso_v, n_done, n_err, n_both);
        chk("snap_miso", miso_v, GOOD);
        chk("snap_led", 48'(led), 48'h3);
        x_pos = 10'h2A5;

        // reset at bit 20 with SS held low
        frame(40, {8'h81, 40'h0}, -1, 20, miso_v, n_done, n_err, n_both);
        chk("rstmid_miso", miso_v, GOOD & 48'hFFFF_F000_0000);
        chk("rstmid_done", 48'(n_done), 48'd0);
        chk("rstmid_err", 48'(n_err), 48'd0);
        chk("rstmid_led", 48'(led), 48'h0);

        // normal frame after mid-frame reset
        frame(40, {8'h81, 40'h0}, -1, -1, miso_v, n_done, n_err, n_both);
        chk("after_rst_miso", miso_v, GOOD);
        chk("after_rst_done", 48'(n_done), 48'd1);
        chk("after_rst_led", 48'(led), 48'h1);
        chk("both_pulse", 48'(n_both), 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
